// File: rtl/bus_pkg.sv
// Shared constants for the datapath bus arbiter/mux: default sizes,
// FSM state encoding and the datapath's named bus source indices.
package bus_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int BUS_NSRC  = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_DIRECT = 2'd3
    } state_t;

    // Datapath source indices on the shared bus
    localparam int R0  = 0,  R1  = 1,  R2  = 2,  R3  = 3;
    localparam int R4  = 4,  R5  = 5,  R6  = 6,  R7  = 7;
    localparam int R8  = 8,  R9  = 9,  R10 = 10, R11 = 11;
    localparam int R12 = 12, R13 = 13, R14 = 14, R15 = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int CSIGN  = 23;

endpackage

// File: rtl/bus_arb_mux_if.sv
// Bus-side signal bundle: source data, requests/locks, direct select and
// the registered bus/ownership outputs. master = control side, slave = arbiter.
interface bus_arb_mux_if
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = BUS_NSRC,
    parameter int SELW  = 5
);
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       req;
    logic [NSRC-1:0]       lock;
    logic                  sel_en;
    logic [SELW-1:0]       sel;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [NSRC-1:0]       grant;
    logic [SELW-1:0]       owner;
    logic                  sel_err;

    modport master (
        output src_data, req, lock, sel_en, sel,
        input  bus_out, bus_valid, grant, owner, sel_err
    );

    modport slave (
        input  src_data, req, lock, sel_en, sel,
        output bus_out, bus_valid, grant, owner, sel_err
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requester strictly after rr_last,
// wrapping, with rr_last itself checked last.
module rr_pick #(
    parameter int NSRC = 24,
    parameter int SELW = 5
) (
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] rr_last,
    output logic            any,
    output logic [SELW-1:0] winner
);

    int              idx;
    logic [SELW-1:0] idx_s;

    // Scan NSRC positions starting one past the last winner
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        idx_s  = '0;
        for (int off = 1; off <= NSRC; off++) begin
            idx = int'(rr_last) + off;
            if (idx >= NSRC) idx = idx - NSRC;
            idx_s = SELW'(idx);
            if (!any && req[idx_s]) begin
                any    = 1'b1;
                winner = idx_s;
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered shared-bus driver: direct select, lock hold or round-robin
// arbitration picks one source; data, grant and owner update together.
module bus_arb_mux
    import bus_pkg::*;
#(
    parameter int               WIDTH    = BUS_WIDTH,
    parameter int               NSRC     = BUS_NSRC,
    parameter int               SELW     = 5,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic          clock,
    input  logic          reset,
    bus_arb_mux_if.slave  bus
);

    state_t                      state;
    logic [SELW-1:0]             rr_last;
    logic [SELW-1:0]             owner_q;
    logic [NSRC-1:0]             grant_q;
    logic [WIDTH-1:0]            bus_q;
    logic                        valid_q;
    logic                        err_q;

    logic [NSRC-1:0][WIDTH-1:0]  src;
    logic [NSRC-1:0]             req_eff;
    logic                        sel_ok;
    logic                        hold;
    logic                        rr_any;
    logic [SELW-1:0]             rr_win;
    logic [SELW-1:0]             mux_idx;
    logic [WIDTH-1:0]            mux_data;

    assign src = bus.src_data;

    // Per-cycle decision inputs: direct-select range, lock hold, masked requests
    always_comb begin
        sel_ok  = int'(bus.sel) < NSRC;
        hold    = (state == ST_LOCKED || state == ST_ARB) &&
                  bus.req[owner_q] && bus.lock[owner_q];
        req_eff = bus.req;
        // A locked owner that releases its lock yields this very cycle
        if (state == ST_LOCKED && !bus.lock[owner_q])
            req_eff[owner_q] = 1'b0;
        if (bus.sel_en)
            mux_idx = sel_ok ? bus.sel : '0;
        else if (hold)
            mux_idx = owner_q;
        else
            mux_idx = rr_win;
        mux_data = src[mux_idx];
    end

    rr_pick #(.NSRC(NSRC), .SELW(SELW)) u_pick (
        .req     (req_eff),
        .rr_last (rr_last),
        .any     (rr_any),
        .winner  (rr_win)
    );

    // Ownership FSM with registered bus, grant and owner
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            rr_last <= SELW'(NSRC - 1);
            owner_q <= '0;
            grant_q <= '0;
            bus_q   <= IDLE_VAL;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.sel_en) begin
                if (sel_ok) begin
                    state   <= ST_DIRECT;
                    owner_q <= bus.sel;
                    grant_q <= NSRC'(1) << bus.sel;
                    bus_q   <= mux_data;
                    valid_q <= 1'b1;
                end else begin
                    state   <= ST_IDLE;
                    owner_q <= '0;
                    grant_q <= '0;
                    bus_q   <= IDLE_VAL;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            end else if (hold) begin
                state   <= ST_LOCKED;
                bus_q   <= mux_data;
                valid_q <= 1'b1;
            end else if (rr_any) begin
                state   <= bus.lock[rr_win] ? ST_LOCKED : ST_ARB;
                owner_q <= rr_win;
                grant_q <= NSRC'(1) << rr_win;
                bus_q   <= mux_data;
                valid_q <= 1'b1;
                rr_last <= rr_win;
            end else begin
                state   <= ST_IDLE;
                owner_q <= '0;
                grant_q <= '0;
                bus_q   <= IDLE_VAL;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.bus_out   = bus_q;
    assign bus.bus_valid = valid_q;
    assign bus.grant     = grant_q;
    assign bus.owner     = owner_q;
    assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: reset, direct select, round-robin,
// lock hold/release, direct override with wrap, reset during lock.
module tb_bus_arb_mux;
    import bus_pkg::*;

    localparam int WIDTH = 32;
    localparam int NSRC  = 24;
    localparam int SELW  = 5;
    localparam logic [WIDTH-1:0] IDLE_VAL = 32'h0;

    logic clock = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    bus_arb_mux_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus ();

    bus_arb_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .IDLE_VAL(IDLE_VAL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] sv(input int i);
        return 32'hA500_0000 | WIDTH'(i * 32'h0101);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int i, input logic [WIDTH-1:0] v);
        bus.src_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".bus"},   64'(bus.bus_out),   64'(IDLE_VAL));
        chk({tag, ".vld"},   64'(bus.bus_valid), 64'd0);
        chk({tag, ".grant"}, 64'(bus.grant),     64'd0);
        chk({tag, ".owner"}, 64'(bus.owner),     64'd0);
    endtask

    task automatic chk_own(input string tag, input int o, input logic [WIDTH-1:0] d);
        logic [NSRC-1:0] g;
        g = '0;
        g[o] = 1'b1;
        chk({tag, ".owner"}, 64'(bus.owner),     64'(o));
        chk({tag, ".grant"}, 64'(bus.grant),     64'(g));
        chk({tag, ".bus"},   64'(bus.bus_out),   64'(d));
        chk({tag, ".vld"},   64'(bus.bus_valid), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int exp_own [5];
        exp_own = '{0, 3, 7, 0, 3};

        reset      = 1'b1;
        bus.req    = '0;
        bus.lock   = '0;
        bus.sel_en = 1'b0;
        bus.sel    = '0;
        for (int i = 0; i < NSRC; i++) set_src(i, sv(i));
        set_src(PC, 32'hDEAD_BEEF);

        // 1: reset state, then idle with no requests
        step();
        chk_idle("rst");
        chk("rst.err", 64'(bus.sel_err), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_idle("idle");
            chk("idle.err", 64'(bus.sel_err), 64'd0);
        end

        // 2: direct select of PC, then out-of-range select
        bus.sel_en = 1'b1;
        bus.sel    = SELW'(PC);
        step();
        chk_own("dir", PC, 32'hDEAD_BEEF);
        chk("dir.err", 64'(bus.sel_err), 64'd0);
        bus.sel = 5'd25;
        step();
        chk("bad.err", 64'(bus.sel_err), 64'd1);
        chk_idle("bad");
        bus.sel_en = 1'b0;
        step();
        chk("bad.pulse", 64'(bus.sel_err), 64'd0);
        chk_idle("bad.after");

        // 3: round-robin over sources 0,3,7
        do_reset();
        bus.req = NSRC'((1 << 0) | (1 << 3) | (1 << 7));
        for (int c = 0; c < 5; c++) begin
            step();
            chk_own($sformatf("rr%0d", c), exp_own[c], sv(exp_own[c]));
        end
        bus.req = '0;

        // 4: source 5 locks while 2 waits; data tracks live; release to 2
        do_reset();
        bus.req[R5]  = 1'b1;
        bus.lock[R5] = 1'b1;
        step();
        chk_own("lk.win", R5, sv(R5));
        bus.req[R2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_src(R5, 32'h5500_0000 + WIDTH'(c));
            step();
            chk_own($sformatf("lk.hold%0d", c), R5, 32'h5500_0000 + WIDTH'(c));
        end
        bus.req[R5] = 1'b0;
        step();
        chk_own("lk.rel", R2, sv(R2));
        bus.req  = '0;
        bus.lock = '0;
        set_src(R5, sv(R5));

        // 5: lock on CSIGN broken by direct select, then wrap to source 1
        do_reset();
        bus.req[CSIGN]  = 1'b1;
        bus.lock[CSIGN] = 1'b1;
        step();
        chk_own("pw.win", CSIGN, sv(CSIGN));
        step();
        chk_own("pw.hold", CSIGN, sv(CSIGN));
        bus.sel_en = 1'b1;
        bus.sel    = SELW'(R4);
        step();
        chk_own("pw.dir", R4, sv(R4));
        bus.sel_en = 1'b0;
        bus.req    = '0;
        bus.lock   = '0;
        bus.req[R1]     = 1'b1;
        bus.req[INPORT] = 1'b1;
        step();
        chk_own("pw.wrap", R1, sv(R1));
        bus.req = '0;

        // 6: reset during a lock drops ownership; source 0 then wins
        do_reset();
        bus.req[R9]  = 1'b1;
        bus.lock[R9] = 1'b1;
        step();
        chk_own("rl.win", R9, sv(R9));
        reset = 1'b1;
        step();
        chk_idle("rl.rst");
        reset = 1'b0;
        bus.req[R0] = 1'b1;
        step();
        chk_own("rl.after", R0, sv(R0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_arb_mux.md
Name: bus_arb_mux

Overview:
Parametrised, registered successor to the combinational datapath bus multiplexer. It drives the shared datapath bus from one of NSRC sources. Sources are chosen by one of two means:
- explicit control-unit select (direct mode), or
- round-robin arbitration over per-source requests, with optional multi-cycle lock (arbitrated mode).

Bus data, grant and owner are registered together, so the bus and its ownership are always cycle-consistent.

Parameters:
WIDTH, 32, bus/source data width in bits
NSRC, 24, number of bus sources (2..32)
SELW, 5, select/owner index width; must satisfy 2**SELW > NSRC
IDLE_VAL, 32'h0, value driven on bus_out when no source owns the bus (WIDTH bits)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
src_data  in  NSRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH]
req  in  NSRC  per-source bus request (arbitrated mode)
lock  in  NSRC  per-source ownership lock; only meaningful for the current owner
sel_en  in  1  direct-mode enable; overrides arbitration
sel  in  SELW  direct-mode source index
bus_out  out  WIDTH  registered bus value
bus_valid  out  1  bus_out carries a source's data
grant  out  NSRC  registered one-hot grant; all-zero when idle
owner  out  SELW  registered index of the granting source; 0 when idle
sel_err  out  1  one-cycle pulse: direct select index out of range

Behaviour:
- Reset (sampled at clock edge) forces:
  - bus_out=IDLE_VAL, bus_valid=0, grant=0, owner=0, sel_err=0
  - state=IDLE, round-robin pointer rr_last=NSRC-1, so source 0 has top priority after reset
- Reset mid-transfer drops ownership immediately; no lock survives reset.
- States:
  - IDLE: no owner
  - ARB: arbitrated owner, unlocked
  - LOCKED: arbitrated owner holding lock
  - DIRECT: owner forced by sel
- All decisions are combinational on the current-cycle inputs and take effect at the next edge. Latency from req/sel to bus_out/grant is 1 cycle.
- Priority per cycle, highest first:
  1. reset
  2. sel_en
  3. locked owner
  4. round-robin arbitration
  5. idle
- Direct mode (sel_en=1):
  - sel<NSRC: owner<=sel, grant<=onehot(sel), bus_out<=src_data[sel], bus_valid<=1, state DIRECT. Existing lock is broken. rr_last is unchanged.
  - sel>=NSRC: bus_out<=IDLE_VAL, bus_valid<=0, grant<=0, sel_err<=1 for one cycle, state IDLE.
- Locked hold: in LOCKED or ARB with req[owner]=1 and lock[owner]=1, owner is retained regardless of other requests. bus_out<=src_data[owner] every cycle (data tracks the source live). State LOCKED.
- Round-robin (no sel_en, no valid lock hold):
  - Winner is the first i with req[i]=1, searching from (rr_last+1) mod NSRC upward with wrap-around.
  - Winner result: owner<=i, grant<=onehot(i), bus_out<=src_data[i], bus_valid<=1, rr_last<=i.
  - Next state is LOCKED if lock[i]=1, else ARB.
  - With no lock, continuous requesters rotate every cycle.
- Release: when the owner deasserts req (or lock in LOCKED), it is excluded that same cycle. Remaining requesters are arbitrated with no idle bubble.
- No requests and no sel_en: bus_out<=IDLE_VAL, bus_valid<=0, grant<=0, owner<=0, state IDLE, rr_last held.
- Leaving DIRECT (sel_en falls) goes straight to arbitration that cycle.
- lock on a non-owner is ignored. req bits beyond activity are don't-care in direct mode.
- Invariant: grant is one-hot or zero; grant!=0 iff bus_valid=1; grant[owner]=1 whenever bus_valid=1.

Decomposition:
- Shared package bus_pkg:
  - WIDTH/NSRC defaults
  - state encoding constants ST_IDLE=2'd0, ST_ARB=2'd1, ST_LOCKED=2'd2, ST_DIRECT=2'd3
  - the datapath's source index constants (R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSIGN=23)
- One sub-module, rr_pick: purely combinational rotating priority encoder.
  - Inputs: req, rr_last
  - Outputs: any, winner index
- Registers, FSM and the data mux stay in bus_arb_mux.

Test Plan:
1. Reset then req=0: bus_out=IDLE_VAL, bus_valid=0, grant=0, owner=0 for all cycles; sel_err stays 0.
2. Direct mode: sel_en=1, sel=20, src 20=32'hDEAD_BEEF. Next cycle bus_out=32'hDEAD_BEEF, owner=20, grant=1<<20. sel=25 gives sel_err pulse of exactly one cycle, bus_valid=0.
3. Round-robin: req[0]=req[3]=req[7]=1 held, no lock, from reset. Owners go 0,3,7,0,3 on consecutive cycles. Each bus_out equals that source's data.
4. Lock hold: src 5 wins with lock[5]=1 while req[2]=1 for 4 cycles; owner stays 5 and bus_out follows src 5 data changes same-latency. Drop req[5]: next cycle owner=2, no idle cycle.
5. Priority and wrap: owner=23 locked, assert sel_en sel=4. Next cycle owner=4 (lock broken). Release sel_en with req[1]=req[22]=1 and rr_last=23: owner=1 (wrap past 0 to 1).
6. Reset mid-lock: owner 9 locked, pulse reset one cycle. Following cycle all outputs at reset values. With req[9]=req[0]=1 afterwards, owner=0.
